// File: rtl/lif_pkg.sv
// Shared constants and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

    localparam int N_NEURONS_DEF   = 8;
    localparam int STATE_W_DEF     = 8;
    localparam int CUR_W_DEF       = 8;
    localparam int LEAK_SHIFT_DEF  = 1;
    localparam int THRESH_INIT_DEF = 127;
    localparam int REFRACT_DEF     = 2;

    // Bits needed to index n entries, never less than one.
    function automatic int idx_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Unsigned add clamped to the largest w-bit value (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] sum;
        logic [31:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (32'd1 << w) - 32'd1;
        if (sum[32] || (sum[31:0] > max_v)) begin
            return max_v;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational update of one neuron: refractory countdown, or
// leak + integrate + saturate followed by the threshold compare.
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int STATE_W    = STATE_W_DEF,
    parameter int CUR_W      = CUR_W_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
    parameter int REFRACT    = REFRACT_DEF,
    parameter int RF_W       = idx_w(REFRACT_DEF + 1)
)(
    input  logic [STATE_W-1:0] v_cur,
    input  logic [STATE_W-1:0] thr_cur,
    input  logic [RF_W-1:0]    refr_cur,
    input  logic [CUR_W-1:0]   cur,
    output logic [STATE_W-1:0] v_next,
    output logic [RF_W-1:0]    refr_next,
    output logic               spike
);

    logic [STATE_W-1:0] leaked_s;
    logic [STATE_W-1:0] sum_s;

    // v - (v >> LEAK_SHIFT) never exceeds v, so it cannot wrap.
    assign leaked_s = v_cur - (v_cur >> LEAK_SHIFT);
    assign sum_s    = STATE_W'(sat_add(32'(leaked_s), 32'(cur), STATE_W));

    // Refractory neurons are parked at zero; otherwise integrate and fire.
    always_comb begin
        v_next    = v_cur;
        refr_next = refr_cur;
        spike     = 1'b0;
        if (refr_cur != {RF_W{1'b0}}) begin
            refr_next = refr_cur - RF_W'(1);
            v_next    = {STATE_W{1'b0}};
        end else if (sum_s >= thr_cur) begin
            spike     = 1'b1;
            v_next    = {STATE_W{1'b0}};
            refr_next = RF_W'(REFRACT);
        end else begin
            v_next    = sum_s;
        end
    end

endmodule

// File: rtl/tm_lif_array.sv
// Time-multiplexed leaky integrate-and-fire array: one shared update
// datapath visits neurons round-robin and commits a spike vector per frame.
module tm_lif_array
    import lif_pkg::*;
#(
    parameter int  N_NEURONS   = N_NEURONS_DEF,
    parameter int  STATE_W     = STATE_W_DEF,
    parameter int  CUR_W       = CUR_W_DEF,
    parameter int  LEAK_SHIFT  = LEAK_SHIFT_DEF,
    parameter int  THRESH_INIT = THRESH_INIT_DEF,
    parameter int  REFRACT     = REFRACT_DEF,
    localparam int IDX_W       = idx_w(N_NEURONS)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_NEURONS*CUR_W-1:0] current,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_addr,
    input  logic [STATE_W-1:0]         cfg_data,
    input  logic [IDX_W-1:0]           mon_addr,
    output logic [STATE_W-1:0]         mon_state,
    output logic [N_NEURONS-1:0]       spike,
    output logic                       frame_valid
);

    localparam int RF_W = idx_w(REFRACT + 1);

    logic [IDX_W-1:0]     idx_r;
    logic [STATE_W-1:0]   v_r    [N_NEURONS];
    logic [STATE_W-1:0]   thr_r  [N_NEURONS];
    logic [RF_W-1:0]      refr_r [N_NEURONS];
    logic [N_NEURONS-1:0] acc_r;
    logic [N_NEURONS-1:0] spike_r;
    logic                 frame_valid_r;
    logic [STATE_W-1:0]   mon_state_r;

    logic [CUR_W-1:0]     cur_sel_s;
    logic [STATE_W-1:0]   v_next_s;
    logic [RF_W-1:0]      refr_next_s;
    logic                 spike_s;
    logic                 last_slot_s;
    logic                 cfg_hit_s;
    logic                 mon_hit_s;

    assign last_slot_s = (idx_r == IDX_W'(N_NEURONS - 1));

    // Address range guards only exist when the index space is not full.
    generate
        if (N_NEURONS == (1 << IDX_W)) begin : g_full_range
            assign cfg_hit_s = cfg_we;
            assign mon_hit_s = 1'b1;
        end else begin : g_part_range
            assign cfg_hit_s = cfg_we && (cfg_addr < IDX_W'(N_NEURONS));
            assign mon_hit_s = (mon_addr < IDX_W'(N_NEURONS));
        end
    endgenerate

    // Pick the current of the neuron under visit.
    always_comb begin
        cur_sel_s = current[idx_r*CUR_W +: CUR_W];
    end

    lif_neuron_update #(
        .STATE_W    (STATE_W),
        .CUR_W      (CUR_W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRACT    (REFRACT),
        .RF_W       (RF_W)
    ) u_update (
        .v_cur     (v_r[idx_r]),
        .thr_cur   (thr_r[idx_r]),
        .refr_cur  (refr_r[idx_r]),
        .cur       (cur_sel_s),
        .v_next    (v_next_s),
        .refr_next (refr_next_s),
        .spike     (spike_s)
    );

    // Slot counter: advances one neuron per enabled cycle and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (en) begin
            idx_r <= last_slot_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Membrane and refractory state: only the visited neuron is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_r[i]    <= {STATE_W{1'b0}};
                refr_r[i] <= {RF_W{1'b0}};
            end
        end else if (en) begin
            v_r[idx_r]    <= v_next_s;
            refr_r[idx_r] <= refr_next_s;
        end else begin
            v_r[idx_r]    <= v_r[idx_r];
            refr_r[idx_r] <= refr_r[idx_r];
        end
    end

    // Threshold table; a same-cycle visit has already compared against the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                thr_r[i] <= STATE_W'(THRESH_INIT);
            end
        end else if (cfg_hit_s) begin
            thr_r[cfg_addr] <= cfg_data;
        end else begin
            thr_r[cfg_addr] <= thr_r[cfg_addr];
        end
    end

    // Spike accumulation and frame commit on the last slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r         <= {N_NEURONS{1'b0}};
            spike_r       <= {N_NEURONS{1'b0}};
            frame_valid_r <= 1'b0;
        end else begin
            frame_valid_r <= en && last_slot_s;
            if (en && last_slot_s) begin
                spike_r <= {spike_s, acc_r[N_NEURONS-2:0]};
                acc_r   <= {N_NEURONS{1'b0}};
            end else if (en) begin
                acc_r[idx_r] <= spike_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Monitor port: pre-update membrane of the selected neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_state_r <= {STATE_W{1'b0}};
        end else if (mon_hit_s) begin
            mon_state_r <= v_r[mon_addr];
        end else begin
            mon_state_r <= {STATE_W{1'b0}};
        end
    end

    assign mon_state   = mon_state_r;
    assign spike       = spike_r;
    assign frame_valid = frame_valid_r;

endmodule

// File: tb/tb_tm_lif_array.sv
// Directed bench for tm_lif_array: frames are scored from a queue of
// hand-computed spike vectors popped by an independent monitor.
module tb_tm_lif_array;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [63:0]  current;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [7:0]   cfg_data;
    logic [2:0]   mon_addr;
    logic [7:0]   mon_state;
    logic [7:0]   spike;
    logic         frame_valid;

    int           total;
    int           bad;
    logic [7:0]   exp_q[$];
    logic [7:0]   last_spike;

    tm_lif_array dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .current     (current),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .mon_addr    (mon_addr),
        .mon_state   (mon_state),
        .spike       (spike),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic set_cur(input int i, input logic [7:0] c);
        current[i*8 +: 8] = c;
    endtask

    // Reset with en high to show reset wins, then check every output.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        last_spike = 8'h00;
        chk("reset_spike", 32'(spike), 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);
        chk("reset_mon_state", 32'(mon_state), 32'h0);
    endtask

    // Read a membrane through the monitor port with the scheduler idle.
    task automatic peek(input logic [2:0] k, input logic [7:0] exp);
        en       = 1'b0;
        mon_addr = k;
        tick();
        chk($sformatf("mon_v%0d", k), 32'(mon_state), 32'(exp));
    endtask

    // One full frame; optional mid-frame pause and a threshold write on one slot.
    task automatic run_frame(input logic [7:0] e, input int pause_at, input int pause_len,
                             input int cfg_slot, input logic [2:0] ca, input logic [7:0] cd);
        exp_q.push_back(e);
        for (int s = 0; s < N; s++) begin
            if (s == pause_at) begin
                en = 1'b0;
                for (int p = 0; p < pause_len; p++) begin
                    tick();
                    chk("pause_frame_valid", 32'(frame_valid), 32'h0);
                    chk("pause_spike_hold", 32'(spike), 32'(last_spike));
                end
            end
            en = 1'b1;
            if (s == cfg_slot) begin
                cfg_we   = 1'b1;
                cfg_addr = ca;
                cfg_data = cd;
            end
            tick();
            cfg_we = 1'b0;
            chk($sformatf("frame_valid_slot%0d", s), 32'(frame_valid), (s == N - 1) ? 32'h1 : 32'h0);
        end
        en = 1'b0;
        last_spike = e;
    endtask

    // Monitor: scores each committed frame against the expectation queue.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL frame_unexpected got=%h exp=none", spike);
                end else begin
                    e = exp_q.pop_front();
                    if (spike !== e) begin
                        bad++;
                        $display("FAIL frame_spike got=%h exp=%h", spike, e);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v0_tab [7];
        logic [7:0] t4_tab [4];
        v0_tab = '{8'd64, 8'd96, 8'd112, 8'd120, 8'd124, 8'd126, 8'd0};
        t4_tab = '{8'h20, 8'h00, 8'h00, 8'h20};
        total = 0;
        bad = 0;
        rst = 1'b1;
        en = 1'b0;
        current = 64'h0;
        cfg_we = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 8'd0;
        mon_addr = 3'd0;
        last_spike = 8'h00;
        tick();
        tick();

        // 1: quiet array, frame_valid only on idx 7.
        do_reset();
        run_frame(8'h00, -1, 0, -1, 3'd0, 8'd0);
        run_frame(8'h00, -1, 0, -1, 3'd0, 8'd0);
        peek(3'd4, 8'd0);

        // 2: constant 64 into neuron 0 climbs to threshold on the 7th frame.
        do_reset();
        set_cur(0, 8'd64);
        for (int f = 0; f < 7; f++) begin
            run_frame((f == 6) ? 8'h01 : 8'h00, -1, 0, -1, 3'd0, 8'd0);
            peek(3'd0, v0_tab[f]);
        end
        run_frame(8'h00, -1, 0, -1, 3'd0, 8'd0);
        peek(3'd0, 8'd0);

        // 3: threshold 255, saturating sum reaches it on frame 2.
        do_reset();
        current = 64'h0;
        cfg_we = 1'b1;
        cfg_addr = 3'd3;
        cfg_data = 8'd255;
        tick();
        cfg_we = 1'b0;
        set_cur(3, 8'd200);
        run_frame(8'h00, -1, 0, -1, 3'd0, 8'd0);
        peek(3'd3, 8'd200);
        run_frame(8'h08, -1, 0, -1, 3'd0, 8'd0);
        peek(3'd3, 8'd0);

        // 4: refractory period of two visits after each spike.
        do_reset();
        current = 64'h0;
        set_cur(5, 8'd255);
        for (int f = 0; f < 4; f++) begin
            run_frame(t4_tab[f], -1, 0, -1, 3'd0, 8'd0);
            peek(3'd5, 8'd0);
        end

        // 5a: pause mid-frame; neuron 5 refractory, neuron 1 fires.
        set_cur(0, 8'd64);
        set_cur(1, 8'd255);
        run_frame(8'h02, 3, 5, -1, 3'd0, 8'd0);
        peek(3'd0, 8'd64);
        // 5b: reset mid-frame beats en and cfg_we.
        mon_addr = 3'd0;
        en = 1'b1;
        for (int s = 0; s < 3; s++) tick();
        rst = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 3'd5;
        cfg_data = 8'd50;
        tick();
        rst = 1'b0;
        cfg_we = 1'b0;
        en = 1'b0;
        last_spike = 8'h00;
        chk("midrst_spike", 32'(spike), 32'h0);
        chk("midrst_frame_valid", 32'(frame_valid), 32'h0);
        chk("midrst_mon_state", 32'(mon_state), 32'h0);
        peek(3'd0, 8'd0);
        current = 64'h0;
        set_cur(5, 8'd100);
        run_frame(8'h00, -1, 0, -1, 3'd0, 8'd0);
        peek(3'd5, 8'd100);

        // 6: threshold write on the visiting cycle uses the old threshold.
        do_reset();
        current = 64'h0;
        set_cur(2, 8'd50);
        run_frame(8'h00, -1, 0, 2, 3'd2, 8'd10);
        peek(3'd2, 8'd50);
        run_frame(8'h04, -1, 0, -1, 3'd0, 8'd0);
        peek(3'd2, 8'd0);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
